// File: rtl/mmul_pkg.sv
// mmul_pkg: shared state encoding and width helpers for the matrix-vector multiplier front end
package mmul_pkg;

    typedef enum logic [2:0] {IDLE, READ, WAIT_DATA, PUSH, DONE} loader_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmul_word_unpacker.sv
// mmul_word_unpacker: holds one memory word and serves its elements LSB-first
module mmul_word_unpacker
    import mmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8,
    parameter int N_WIDTH    = cnt_width(N)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic                    i_load,
    input  logic [DATA_WIDTH*N-1:0] i_word,
    input  logic                    i_advance,
    output logic [DATA_WIDTH-1:0]   o_elem,
    output logic                    o_last
);

    logic [DATA_WIDTH*N-1:0] word_buf;
    logic [N_WIDTH-1:0]      elem_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_buf <= '0;
            elem_idx <= '0;
        end else if (i_clr) begin
            elem_idx <= '0;
        end else if (i_load) begin
            word_buf <= i_word;
            elem_idx <= '0;
        end else if (i_advance) begin
            elem_idx <= o_last ? '0 : elem_idx + N_WIDTH'(1);
        end
    end

    assign o_elem = word_buf[elem_idx*DATA_WIDTH +: DATA_WIDTH];
    assign o_last = elem_idx == N_WIDTH'(N - 1);

endmodule

// File: rtl/mmul_loader.sv
// mmul_loader: fetches matrix A rows and vector B over Avalon-MM and steers their elements into the FIFOs
module mmul_loader
    import mmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8,
    parameter int M          = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int N_WIDTH    = cnt_width(N),
    parameter int W_WIDTH    = cnt_width(M + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_clr,
    input  logic [ADDR_WIDTH-1:0]        i_base_addr,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [ADDR_WIDTH-1:0]        o_mem_addr,
    output logic                         o_mem_read,
    input  logic [DATA_WIDTH*N-1:0]      i_mem_readdata,
    input  logic                         i_mem_readdatavalid,
    input  logic                         i_mem_waitrequest,
    output logic [M-1:0][DATA_WIDTH-1:0] o_a,
    output logic [M-1:0]                 o_a_valid,
    input  logic [M-1:0]                 i_a_full,
    output logic [DATA_WIDTH-1:0]        o_b,
    output logic                         o_b_valid,
    input  logic                         i_b_full
);

    loader_state_t           state;
    logic [ADDR_WIDTH-1:0]   base;
    logic [W_WIDTH-1:0]      word_idx;
    logic [M:0]              full_all;
    logic [M:0]              vld_all;
    logic                    push;
    logic                    load;
    logic                    last;
    logic [DATA_WIDTH-1:0]   elem;

    // word index M selects the B FIFO, so both full and valid are indexed as one M+1 vector
    assign full_all  = {i_b_full, i_a_full};
    assign push      = (state == PUSH) && !full_all[word_idx] && !i_clr;
    assign vld_all   = push ? (M + 1)'(1) << word_idx : '0;
    assign o_a_valid = vld_all[M-1:0];
    assign o_b_valid = vld_all[M];
    assign o_a       = {M{elem}};
    assign o_b       = elem;
    assign load      = (state == WAIT_DATA) && i_mem_readdatavalid && !i_clr;

    mmul_word_unpacker #(
        .DATA_WIDTH(DATA_WIDTH),
        .N         (N),
        .N_WIDTH   (N_WIDTH)
    ) u_unpacker (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (i_clr),
        .i_load   (load),
        .i_word   (i_mem_readdata),
        .i_advance(push),
        .o_elem   (elem),
        .o_last   (last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            base       <= '0;
            word_idx   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_mem_read <= 1'b0;
            o_mem_addr <= '0;
        end else begin
            o_done <= 1'b0;
            if (i_clr) begin
                state      <= IDLE;
                word_idx   <= '0;
                o_busy     <= 1'b0;
                o_mem_read <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (i_start) begin
                        state      <= READ;
                        base       <= i_base_addr;
                        word_idx   <= '0;
                        o_busy     <= 1'b1;
                        o_mem_read <= 1'b1;
                        o_mem_addr <= i_base_addr;
                    end
                    READ: if (!i_mem_waitrequest) begin
                        state      <= WAIT_DATA;
                        o_mem_read <= 1'b0;
                    end
                    WAIT_DATA: if (i_mem_readdatavalid) state <= PUSH;
                    PUSH: if (push && last) begin
                        if (word_idx == W_WIDTH'(M)) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            state      <= READ;
                            word_idx   <= word_idx + W_WIDTH'(1);
                            o_mem_read <= 1'b1;
                            o_mem_addr <= base + ADDR_WIDTH'(word_idx) + ADDR_WIDTH'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
